dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single read/write port of the data memory between the pipeline
//  memory stage (CPU) and a burst-mode block-transfer engine (DMA). CPU
//  accesses are single-beat and take priority. DMA bursts are non-preemptible
//  and protected from starvation. Read data is tagged and routed back to the
//  requester that issued it, so the memory stage keeps its pipeline buffer unchanged.
// PARAMETERS
//  ADDR_W        19  memory word-address width
//  DATA_W        24  data word width
//  MAX_BURST     16  max DMA beats per burst; dma_len above this is clamped
//  STARVE_LIMIT  8   DMA waiting cycles before DMA beats CPU in IDLE
//  READ_LAT      1   memory read latency in cycles (1..4)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  cpu_req    in   1       CPU access request (one beat)
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_gnt    out  1       beat accepted this cycle
//  cpu_stall  out  1       cpu_req & ~cpu_gnt; freezes pipeline
//  cpu_rvalid out  1       CPU read data valid
//  dma_req    in   1       burst request; held until first dma_gnt
//  dma_we     in   1       burst direction, sampled at start
//  dma_addr   in   ADDR_W  burst base address, sampled at start
//  dma_len    in   5       beats, sampled at start
//  dma_wdata  in   DATA_W  write data for the current beat
//  dma_gnt    out  1       DMA beat issued; present the next wdata after it
//  dma_rvalid out  1       DMA read data valid
//  dma_done   out  1       one-cycle pulse, burst complete
//  rdata      out  DATA_W  mem_rdata forwarded to both requesters
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, READ_LAT after address
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. Starvation counter, beat counter and tag pipe are
//    cleared. All outputs are 0.
//  - Reset during a burst aborts it. No dma_done is produced, and in-flight
//    rvalids are dropped.
//  - FSM states are IDLE, BURST and DRAIN.
//  - IDLE arbitration:
//    - cpu_req wins, unless starve_cnt>=STARVE_LIMIT and dma_req=1, in which
//      case the DMA wins.
//    - A CPU grant is combinational. cpu_gnt=1, mem_* are driven from the
//      cpu_* inputs, and the state stays IDLE, so back-to-back CPU beats run
//      every cycle.
//    - A DMA grant issues beat 0 in the same cycle and latches addr/we/len.
//      The next state is BURST if len>1. Otherwise the next state is DRAIN
//      for a read, or the FSM pulses dma_done next cycle for a write.
//  - dma_len: 0 is ignored (no grant, dma_req is held). Values >MAX_BURST
//    are treated as MAX_BURST.
//  - BURST:
//    - One DMA beat per cycle, with dma_gnt=1 on each beat.
//    - The address increments by 1 modulo 2^ADDR_W, wrapping all-ones to 0.
//    - The CPU is not granted; cpu_stall follows cpu_req.
//    - After the last beat:
//      - write: go to IDLE, and dma_done=1 in the cycle after the last beat.
//      - read: go to DRAIN.
//  - DRAIN: wait until the last DMA read returns. dma_done=1 in the same cycle
//    as the last dma_rvalid, then go to IDLE. The CPU may be granted in DRAIN.
//    DMA is not re-granted until IDLE.
//  - starve_cnt: increments (saturating) each cycle dma_req=1 without a DMA
//    grant. It clears on a DMA grant or when dma_req=0.
//  - Read return: a READ_LAT-deep shift register of {valid,owner} is loaded on
//    every read beat. At its output, cpu_rvalid or dma_rvalid is asserted.
//    rdata=mem_rdata is unregistered.
//  - A write beat drives mem_we=1 only in its issue cycle. mem_we=0 whenever
//    no beat is issued.
// TESTING
//  1. CPU read at 0x00010 (memory holds 0xABCDEF): cpu_gnt in the same cycle,
//     cpu_rvalid=1 and rdata=0xABCDEF one cycle later, cpu_stall=0.
//  2. DMA write, base 0x7FFFE, len 4: writes go to 0x7FFFE, 0x7FFFF, 0x00000,
//     0x00001 on 4 consecutive dma_gnt cycles; dma_done in the next cycle.
//  3. cpu_req held at 1 with dma_req=1: CPU is granted for 8 cycles, then the
//     DMA wins. A len 4 burst gives cpu_stall=1 for 4 cycles.
//  4. dma_len=0 gives no dma_gnt for 20 cycles. dma_len=20 gives exactly 16
//     beats and one dma_done.
//  5. DMA read, len 3, READ_LAT=1: 3 consecutive dma_rvalid, with dma_done on
//     the third. A CPU read issued in DRAIN gets cpu_rvalid and no dma_rvalid.
//  6. rst=1 after beat 2 of a len 8 burst: all outputs are 0 the next cycle;
//     no further beats, rvalids or dma_done.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: single-beat CPU accesses with priority,
// non-preemptible DMA bursts with starvation guard, tagged read-data return.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned READ_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [4:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [CNT_W-1:0]    r_left;
  logic [STV_W-1:0]    r_starve;
  logic                r_wdone;
  logic [READ_LAT-1:0] r_tv;
  logic [READ_LAT-1:0] r_to;
  logic [READ_LAT-1:0] r_tl;

  logic             w_cpu_gnt;
  logic             w_dma_gnt;
  logic             w_dma_start;
  logic             w_beat_last;
  logic             w_rd_issue;
  logic             w_starved;
  logic [CNT_W-1:0] w_eff_len;
  logic             w_ret_cpu;
  logic             w_ret_dma;
  logic             w_last_ret;

  assign w_starved  = 32'(r_starve) >= STARVE_LIMIT;
  assign w_ret_cpu  = r_tv[READ_LAT-1] & ~r_to[READ_LAT-1];
  assign w_ret_dma  = r_tv[READ_LAT-1] &  r_to[READ_LAT-1];
  assign w_last_ret = w_ret_dma & r_tl[READ_LAT-1];

  always_comb begin
    if (32'(dma_len) > MAX_BURST) w_eff_len = CNT_W'(MAX_BURST);
    else                          w_eff_len = CNT_W'(dma_len);
  end

  // Grant decision and memory port mux; every issue path is suppressed while rst is high.
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_dma_start = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (dma_req && dma_len != '0 && (!cpu_req || w_starved)) begin
            w_dma_start = 1'b1;
            w_dma_gnt   = 1'b1;
          end else begin
            w_cpu_gnt = cpu_req;
          end
        end
        S_BURST: w_dma_gnt = 1'b1;
        S_DRAIN: w_cpu_gnt = cpu_req;
        default: ;
      endcase
    end
    w_beat_last = w_dma_start ? (w_eff_len == CNT_W'(1)) : (r_left == CNT_W'(1));

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dma_start) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (w_dma_gnt) begin
      mem_we    = r_we;
      mem_addr  = r_addr;
      mem_wdata = dma_wdata;
    end
    w_rd_issue = (w_cpu_gnt | w_dma_gnt) & ~mem_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_left   <= '0;
      r_starve <= '0;
      r_wdone  <= 1'b0;
      r_tv     <= '0;
      r_to     <= '0;
      r_tl     <= '0;
    end else begin
      r_wdone <= 1'b0;
      r_tv    <= (r_tv << 1) | READ_LAT'(w_rd_issue);
      r_to    <= (r_to << 1) | READ_LAT'(w_dma_gnt);
      r_tl    <= (r_tl << 1) | READ_LAT'(w_dma_gnt & w_beat_last);

      if (dma_req && !w_dma_gnt) begin
        if (!w_starved) r_starve <= r_starve + STV_W'(1);
      end else begin
        r_starve <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_dma_start) begin
            r_addr <= dma_addr + ADDR_W'(1);
            r_we   <= dma_we;
            r_left <= w_eff_len - CNT_W'(1);
            if (w_eff_len > CNT_W'(1)) r_state <= S_BURST;
            else if (dma_we)           r_wdone <= 1'b1;
            else                       r_state <= S_DRAIN;
          end
        end
        S_BURST: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_left <= r_left - CNT_W'(1);
          if (r_left == CNT_W'(1)) begin
            if (r_we) begin
              r_wdone <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: if (w_last_ret) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt & ~rst;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = w_ret_cpu & ~rst;
  assign dma_rvalid = w_ret_dma & ~rst;
  assign dma_done   = (r_wdone | w_last_ret) & ~rst;
  assign busy       = (r_state != S_IDLE) & ~rst;
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: constant vector table, directed corner sequences,
// and random traffic against a queue-based transaction model.
module tb_dmem_port_arbiter;
  localparam int AW = 19, DW = 24, MAXB = 16, SLIM = 8, RL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [4:0]    dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid, dma_done;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB),
                      .STARVE_LIMIT(SLIM), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Environment memory with one cycle of read latency
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd_q;
  function automatic logic [DW-1:0] defval(input logic [AW-1:0] a);
    return {5'b0, a} ^ 24'h5A5A5A;
  endfunction
  always @(posedge clk) begin
    rd_q <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : defval(mem_addr);
    if (mem_we) mem[int'(mem_addr)] = mem_wdata;
  end
  assign mem_rdata = rd_q;

  // Reference model: pending beats and pending returns held as queues
  typedef struct { int due; bit dma; bit last; logic [DW-1:0] data; } ret_t;
  typedef struct { logic [AW-1:0] a; bit last; } beat_t;
  ret_t          rq[$];
  beat_t         bq[$];
  bit            m_bwe;
  int            m_starve = 0;
  int            m_done_due = -1;
  int            cyc = 0;
  logic [DW-1:0] sh [int];

  function automatic logic [DW-1:0] shread(input logic [AW-1:0] a);
    return sh.exists(int'(a)) ? sh[int'(a)] : defval(a);
  endfunction

  task automatic cyc_check();
    bit e_cg, e_dg, e_we, e_crv, e_drv, e_done, e_busy, e_st, issue, own_dma, last, chk_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    int dma_out, n;
    ret_t r;
    beat_t b;
    #2;
    {e_cg, e_dg, e_we, e_crv, e_drv, e_done, e_busy, issue, own_dma, last, chk_rd} = '0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    if (!rst) begin
      dma_out = 0;
      foreach (rq[i]) if (rq[i].dma) dma_out++;
      e_busy = (bq.size() > 0) || (dma_out > 0);
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_crv = !r.dma; e_drv = r.dma; chk_rd = 1'b1; e_rd = r.data;
        if (r.dma && r.last) e_done = 1'b1;
      end
      if (m_done_due == cyc) e_done = 1'b1;
      if (bq.size() > 0) begin
        b = bq.pop_front();
        issue = 1'b1; own_dma = 1'b1; e_addr = b.a; e_we = m_bwe; e_wd = dma_wdata; last = b.last;
      end else if (dma_out == 0 && dma_req && dma_len != 0 && (!cpu_req || m_starve >= SLIM)) begin
        n = (int'(dma_len) > MAXB) ? MAXB : int'(dma_len);
        m_bwe = dma_we;
        issue = 1'b1; own_dma = 1'b1; e_addr = dma_addr; e_we = dma_we; e_wd = dma_wdata;
        last = (n == 1);
        for (int k = 1; k < n; k++) bq.push_back('{a: dma_addr + AW'(k), last: (k == n - 1)});
      end else if (cpu_req) begin
        issue = 1'b1; own_dma = 1'b0; e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
      end
      if (issue) begin
        e_dg = own_dma; e_cg = !own_dma;
        if (e_we) begin
          sh[int'(e_addr)] = e_wd;
          if (own_dma && last) m_done_due = cyc + 1;
        end else begin
          rq.push_back('{due: cyc + RL, dma: own_dma, last: own_dma && last, data: shread(e_addr)});
        end
      end
      if (dma_req && !e_dg) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
      else                  m_starve = 0;
    end else begin
      rq.delete(); bq.delete(); m_starve = 0; m_done_due = -1;
    end
    e_st = cpu_req && !e_cg && !rst;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_st));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    chk("dma_gnt", 32'(dma_gnt), 32'(e_dg));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
    chk("dma_done", 32'(dma_done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    if (chk_rd) chk("rdata", 32'(rdata), 32'(e_rd));
  endtask

  task automatic cyc_end();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clr();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1;
    cyc_check(); cyc_end();
    rst = 1'b0;
  endtask

  typedef struct {
    logic creq, cwe; logic [AW-1:0] caddr;
    logic dreq, dwe; logic [4:0] dlen; logic [AW-1:0] daddr;
    logic e_cg, e_dg, e_we; logic [AW-1:0] e_addr;
  } vec_t;

  initial begin
    vec_t tv[8];
    logic [AW-1:0] t2a[4];
    int ng, nd, nrv, nst, nany;
    bit g;

    tv[0] = '{1'b1, 1'b0, 19'h5, 1'b0, 1'b0, 5'd0,  19'h0,     1'b1, 1'b0, 1'b0, 19'h5};
    tv[1] = '{1'b1, 1'b1, 19'h6, 1'b0, 1'b0, 5'd0,  19'h0,     1'b1, 1'b0, 1'b1, 19'h6};
    tv[2] = '{1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 5'd4,  19'h40,    1'b0, 1'b1, 1'b0, 19'h40};
    tv[3] = '{1'b1, 1'b0, 19'h7, 1'b1, 1'b1, 5'd4,  19'h50,    1'b1, 1'b0, 1'b0, 19'h7};
    tv[4] = '{1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 5'd0,  19'h60,    1'b0, 1'b0, 1'b0, 19'h0};
    tv[5] = '{1'b1, 1'b1, 19'h8, 1'b1, 1'b1, 5'd0,  19'h60,    1'b1, 1'b0, 1'b1, 19'h8};
    tv[6] = '{1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 5'd0,  19'h0,     1'b0, 1'b0, 1'b0, 19'h0};
    tv[7] = '{1'b0, 1'b0, 19'h0, 1'b1, 1'b1, 5'd20, 19'h7FFFF, 1'b0, 1'b1, 1'b1, 19'h7FFFF};
    t2a[0] = 19'h7FFFE; t2a[1] = 19'h7FFFF; t2a[2] = 19'h0; t2a[3] = 19'h1;

    mem[16] = 24'hABCDEF;
    sh[16]  = 24'hABCDEF;
    clr(); rst = 1'b1;

    // Arbitration table, each row from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cpu_req = tv[i].creq; cpu_we = tv[i].cwe; cpu_addr = tv[i].caddr; cpu_wdata = 24'h111;
      dma_req = tv[i].dreq; dma_we = tv[i].dwe; dma_len = tv[i].dlen; dma_addr = tv[i].daddr;
      dma_wdata = 24'h222;
      cyc_check();
      chk($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(tv[i].e_cg));
      chk($sformatf("vec%0d_dma_gnt", i), 32'(dma_gnt), 32'(tv[i].e_dg));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(tv[i].e_we));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
      chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(0));
      cyc_end();
    end

    // CPU read with one-cycle return
    do_reset();
    cpu_req = 1; cpu_addr = 19'h10;
    cyc_check();
    chk("t1_gnt", 32'(cpu_gnt), 32'(1));
    chk("t1_stall", 32'(cpu_stall), 32'(0));
    cyc_end();
    clr();
    cyc_check();
    chk("t1_rvalid", 32'(cpu_rvalid), 32'(1));
    chk("t1_rdata", 32'(rdata), 32'hABCDEF);
    cyc_end();

    // DMA write burst wrapping the address space
    do_reset();
    dma_req = 1; dma_we = 1; dma_addr = 19'h7FFFE; dma_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      dma_wdata = DW'(24'h100 + i);
      cyc_check();
      chk("t2_gnt", 32'(dma_gnt), 32'(1));
      chk("t2_addr", 32'(mem_addr), 32'(t2a[i]));
      chk("t2_we", 32'(mem_we), 32'(1));
      cyc_end();
      dma_req = 0;
    end
    cyc_check();
    chk("t2_done", 32'(dma_done), 32'(1));
    cyc_end();

    // Starvation: CPU wins 8 cycles, then DMA; burst stalls CPU 4 cycles
    do_reset();
    cpu_req = 1; cpu_addr = 19'h3;
    dma_req = 1; dma_we = 1; dma_addr = 19'h200; dma_len = 5'd4;
    for (int i = 0; i < 8; i++) begin
      cyc_check();
      chk("t3_cpu_gnt", 32'(cpu_gnt), 32'(1));
      chk("t3_dma_held", 32'(dma_gnt), 32'(0));
      cyc_end();
    end
    cyc_check();
    chk("t3_dma_win", 32'(dma_gnt), 32'(1));
    nst = int'(cpu_stall);
    cyc_end();
    dma_req = 0;
    for (int i = 0; i < 5; i++) begin
      cyc_check(); nst += int'(cpu_stall); cyc_end();
    end
    chk("t3_stall_cycles", 32'(nst), 32'(4));

    // Zero length ignored; oversized length clamped
    do_reset();
    dma_req = 1; dma_we = 1; dma_addr = 19'h300; dma_len = 5'd0;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      cyc_check(); ng += int'(dma_gnt); cyc_end();
    end
    chk("t4_len0_gnts", 32'(ng), 32'(0));
    dma_len = 5'd20; ng = 0; nd = 0;
    for (int i = 0; i < 24; i++) begin
      dma_wdata = DW'($urandom);
      cyc_check(); ng += int'(dma_gnt); nd += int'(dma_done); g = dma_gnt;
      cyc_end();
      if (g) dma_req = 0;
    end
    chk("t4_len20_beats", 32'(ng), 32'(16));
    chk("t4_len20_done", 32'(nd), 32'(1));

    // DMA read len 3, CPU read granted in DRAIN
    do_reset();
    dma_req = 1; dma_we = 0; dma_addr = 19'h20; dma_len = 5'd3;
    nrv = 0; nd = 0;
    for (int c = 0; c < 6; c++) begin
      cpu_req = (c == 3);
      cyc_check();
      nrv += int'(dma_rvalid); nd += int'(dma_done);
      if (c == 3) begin
        chk("t5_done_on_last", 32'(dma_done), 32'(1));
        chk("t5_drain_busy", 32'(busy), 32'(1));
        chk("t5_cpu_gnt_drain", 32'(cpu_gnt), 32'(1));
      end
      if (c == 4) begin
        chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'(1));
        chk("t5_no_dma_rvalid", 32'(dma_rvalid), 32'(0));
      end
      cyc_end();
      dma_req = 0;
    end
    chk("t5_rvalids", 32'(nrv), 32'(3));
    chk("t5_done_count", 32'(nd), 32'(1));

    // Reset mid-burst aborts cleanly
    do_reset();
    dma_req = 1; dma_we = 0; dma_addr = 19'h100; dma_len = 5'd8;
    for (int c = 0; c < 3; c++) begin
      cyc_check(); chk("t6_beat", 32'(dma_gnt), 32'(1)); cyc_end();
      dma_req = 0;
    end
    rst = 1'b1;
    cyc_check(); cyc_end();
    rst = 1'b0;
    cyc_check();
    chk("t6_zero_out", {16'(0), cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dma_done,
                        mem_we, busy, 8'(0)}, 32'(0));
    chk("t6_zero_addr", 32'(mem_addr), 32'(0));
    chk("t6_zero_wdata", 32'(mem_wdata), 32'(0));
    cyc_end();
    nany = 0;
    for (int c = 0; c < 10; c++) begin
      cyc_check(); nany += int'(dma_gnt) + int'(dma_rvalid) + int'(dma_done) + int'(cpu_rvalid);
      cyc_end();
    end
    chk("t6_quiet_after_abort", 32'(nany), 32'(0));

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = AW'($urandom_range(0, 63));
      cpu_wdata = DW'($urandom);
      dma_req   = ($urandom_range(0, 3) == 0);
      dma_we    = $urandom_range(0, 1) == 1;
      dma_addr  = ($urandom_range(0, 3) == 0) ? AW'(32'h7FFF8 + $urandom_range(0, 7))
                                               : AW'($urandom_range(0, 63));
      dma_len   = 5'($urandom_range(0, 20));
      dma_wdata = DW'($urandom);
      cyc_check();
      cyc_end();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
